// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: memory-mapped byte FIFO that drains into MiniUART.
// Ports: clk/clr, Bridge stb/we/addr/wd/rd, irq, uart_wd/uart_we/uart_busy.
module uart_tx_buffer #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic [7:0]  uart_wd,
  output logic        uart_we,
  input  logic        uart_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic [7:0]    thr_q, thr_d;
  logic [7:0]    uwd_q, uwd_d;
  logic          irq_q, irq_d;

  logic wr_en, full, empty;
  logic push, pop, flush;
  logic unused;

  assign unused = ^wd[31:16];

  assign wr_en = stb & we;
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign flush = wr_en & (addr == 2'd3);
  assign push  = wr_en & (addr == 2'd0) & ~full;
  // Flush discards the FIFO, so nothing is popped that cycle.
  assign pop   = (state_q == IDLE) & ~empty
               & ~uart_busy & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop) state_d = SEND;
      SEND: state_d = HOLD;
      // HOLD ignores busy: the UART raises it a cycle late.
      HOLD: state_d = WAIT;
      WAIT: if (!uart_busy) state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    ie_d   = ie_q;
    thr_d  = thr_q;
    uwd_d  = uwd_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      uwd_d  = mem_q[rptr_q];
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (wr_en & (addr == 2'd0) & full)
      ovf_d = 1'b1;
    if (wr_en & (addr == 2'd1))
      ovf_d = 1'b0;
    if (wr_en & (addr == 2'd2)) begin
      ie_d  = wd[0];
      thr_d = wd[15:8];
    end
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
    irq_d = ie_q & (32'(cnt_q) <= 32'(thr_q));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ie_q    <= 1'b0;
      thr_q   <= '0;
      uwd_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ie_q    <= ie_d;
      thr_q   <= thr_d;
      uwd_q   <= uwd_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rd = '0;
    unique case (addr)
      2'd1: begin
        rd[AW:0] = cnt_q;
        rd[16]   = empty;
        rd[17]   = full;
        rd[18]   = ovf_q;
        rd[19]   = (state_q != IDLE);
      end
      2'd2: begin
        rd[0]    = ie_q;
        rd[15:8] = thr_q;
      end
      default: rd = '0;
    endcase
  end

  assign uart_we = (state_q == SEND);
  assign uart_wd = uwd_q;
  assign irq     = irq_q;

endmodule
